// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router: buffers payload bytes in a FIFO, then frames
// header, payload and parity onto the router bus, holding the current byte while busy.
module router_pkt_tx #(
  parameter int FIFO_DEPTH = 64,
  parameter int IFG        = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pl_valid,
  input  logic [7:0]       pl_data,
  output logic             pl_ready,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_addr,
  input  logic [5:0]       cmd_len,
  input  logic             cmd_corrupt,
  output logic             cmd_ready,
  output logic [7:0]       data,
  output logic             pkt_valid,
  input  logic             busy,
  input  logic             err,
  output logic             tx_done,
  output logic             tx_rej,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, HDR, PAY, PAR, GAP} state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [7:0]      parity;
  logic [5:0]      rem;
  logic            corrupt;
  logic [3:0]      gap_cnt;
  logic            err_q;
  logic            fifo_wr, fifo_rd, cmd_illegal;
  logic [7:0]      fifo_head;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign pl_ready    = (count < CW'(FIFO_DEPTH));
  assign fifo_wr     = pl_valid & pl_ready;
  assign cmd_illegal = (cmd_addr == 2'd3) || (cmd_len == 6'd0);
  assign cmd_ready   = (state == IDLE) && (cmd_illegal || (count >= CW'(cmd_len)));
  // A pop happens only when the byte on the bus is consumed and more payload remains.
  assign fifo_rd     = !busy && ((state == HDR) || ((state == PAY) && (rem != 6'd0)));
  assign fifo_head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= pl_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (fifo_rd) rd_ptr <= ptr_inc(rd_ptr);
      case ({fifo_wr, fifo_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      data      <= '0;
      pkt_valid <= 1'b0;
      parity    <= '0;
      rem       <= '0;
      corrupt   <= 1'b0;
      gap_cnt   <= '0;
      tx_done   <= 1'b0;
      tx_rej    <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      tx_done <= 1'b0;
      tx_rej  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            if (cmd_illegal) begin
              tx_rej <= 1'b1;
            end else begin
              data      <= {cmd_len, cmd_addr};
              parity    <= {cmd_len, cmd_addr};
              pkt_valid <= 1'b1;
              rem       <= cmd_len;
              corrupt   <= cmd_corrupt;
              state     <= HDR;
            end
          end
        end
        HDR, PAY: begin
          if (!busy) begin
            if (fifo_rd) begin
              data   <= fifo_head;
              parity <= parity ^ fifo_head;
              rem    <= rem - 6'd1;
              state  <= PAY;
            end else begin
              data      <= parity ^ {7'b0, corrupt};
              pkt_valid <= 1'b0;
              state     <= PAR;
            end
          end
        end
        PAR: begin
          if (!busy) begin
            tx_done <= 1'b1;
            pkt_cnt <= pkt_cnt + CNT_W'(1);
            data    <= '0;
            gap_cnt <= 4'(IFG - 1);
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0) state <= IDLE;
          else                 gap_cnt <= gap_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Router error flag counted on rising edges only, saturating at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q   <= 1'b0;
      err_cnt <= '0;
    end else begin
      err_q <= err;
      if (err && !err_q && (err_cnt != {CNT_W{1'b1}})) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule
